// File: rtl/centroid_converge_unit_if.sv
// Bus bundle for centroid_converge_unit: pass request, centroid snapshots and
// convergence results. master drives requests, slave is the convergence unit.
interface centroid_converge_unit_if #(
    parameter int K      = 8,
    parameter int D      = 4,
    parameter int W      = 8,
    parameter int ITER_W = 8
);
    logic                  start;
    logic [K*D*W-1:0]      old_c;
    logic [K*D*W-1:0]      new_c;
    logic [W-1:0]          tol;
    logic [ITER_W-1:0]     max_iter;
    logic                  iter_clr;
    logic                  busy;
    logic                  done;
    logic                  converged;
    logic                  timeout;
    logic [W:0]            max_delta;
    logic [ITER_W-1:0]     iter_cnt;

    modport master (
        output start, old_c, new_c, tol, max_iter, iter_clr,
        input  busy, done, converged, timeout, max_delta, iter_cnt
    );

    modport slave (
        input  start, old_c, new_c, tol, max_iter, iter_clr,
        output busy, done, converged, timeout, max_delta, iter_cnt
    );
endinterface

// File: rtl/centroid_converge_unit.sv
// Compares two centroid sets element by element, P elements per cycle, and
// reports convergence, the largest |new-old| and an iteration-limit timeout.
module centroid_converge_unit #(
    parameter int K      = 8,
    parameter int D      = 4,
    parameter int W      = 8,
    parameter int P      = 1,
    parameter int ITER_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    centroid_converge_unit_if.slave bus
);
    localparam int E  = K * D;
    localparam int N  = E / P;
    localparam int SW = (N > 1) ? $clog2(N) : 1;

    if ((E % P) != 0) begin : g_cfg_err
        $error("centroid_converge_unit: K*D must be divisible by P");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [SW-1:0]       slice_q, slice_d;
    logic [E*W-1:0]      old_q, old_d;
    logic [E*W-1:0]      new_q, new_d;
    logic [W-1:0]        tol_q, tol_d;
    logic [W:0]          acc_max_q, acc_max_d;
    logic                acc_ok_q, acc_ok_d;
    logic                conv_q, conv_d;
    logic                tout_q, tout_d;
    logic [W:0]          mdel_q, mdel_d;
    logic [ITER_W-1:0]   iter_q, iter_d;

    logic [W:0]          slice_max;
    logic                slice_ok;
    logic [W:0]          fin_max;
    logic                fin_ok;
    logic [ITER_W-1:0]   iter_inc;

    // Snapshots shift down by one slice per SCAN cycle, so the current slice
    // always sits in the low P*W bits and no variable part-select is needed.
    always_comb begin
        logic [W:0] a_ext;
        logic [W:0] b_ext;
        logic [W:0] diff;
        logic [W:0] mag;
        a_ext     = '0;
        b_ext     = '0;
        diff      = '0;
        mag       = '0;
        slice_max = '0;
        slice_ok  = 1'b1;
        for (int unsigned p = 0; p < P; p++) begin
            a_ext = {old_q[p*W + W - 1], old_q[p*W +: W]};
            b_ext = {new_q[p*W + W - 1], new_q[p*W +: W]};
            diff  = b_ext - a_ext;
            mag   = diff[W] ? (~diff + 1'b1) : diff;
            if (mag > slice_max) begin
                slice_max = mag;
            end
            if (mag > {1'b0, tol_q}) begin
                slice_ok = 1'b0;
            end
        end
    end

    assign fin_max  = (slice_max > acc_max_q) ? slice_max : acc_max_q;
    assign fin_ok   = acc_ok_q & slice_ok;
    assign iter_inc = (&iter_q) ? iter_q : iter_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        slice_d   = slice_q;
        old_d     = old_q;
        new_d     = new_q;
        tol_d     = tol_q;
        acc_max_d = acc_max_q;
        acc_ok_d  = acc_ok_q;
        conv_d    = conv_q;
        tout_d    = tout_q;
        mdel_d    = mdel_q;
        iter_d    = iter_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d   = SCAN;
                    old_d     = bus.old_c;
                    new_d     = bus.new_c;
                    tol_d     = bus.tol;
                    slice_d   = '0;
                    acc_max_d = '0;
                    acc_ok_d  = 1'b1;
                end
            end
            SCAN: begin
                old_d     = old_q >> (P * W);
                new_d     = new_q >> (P * W);
                acc_max_d = fin_max;
                acc_ok_d  = fin_ok;
                slice_d   = slice_q + 1'b1;
                if (slice_q == SW'(N - 1)) begin
                    state_d = DONE;
                    conv_d  = fin_ok;
                    mdel_d  = fin_max;
                    iter_d  = iter_inc;
                    tout_d  = !fin_ok && (bus.max_iter != '0) && (iter_inc >= bus.max_iter);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Clearing overrides the increment even on the edge entering DONE.
        if (bus.iter_clr) begin
            iter_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            slice_q   <= '0;
            old_q     <= '0;
            new_q     <= '0;
            tol_q     <= '0;
            acc_max_q <= '0;
            acc_ok_q  <= 1'b0;
            conv_q    <= 1'b0;
            tout_q    <= 1'b0;
            mdel_q    <= '0;
            iter_q    <= '0;
        end else begin
            state_q   <= state_d;
            slice_q   <= slice_d;
            old_q     <= old_d;
            new_q     <= new_d;
            tol_q     <= tol_d;
            acc_max_q <= acc_max_d;
            acc_ok_q  <= acc_ok_d;
            conv_q    <= conv_d;
            tout_q    <= tout_d;
            mdel_q    <= mdel_d;
            iter_q    <= iter_d;
        end
    end

    assign bus.busy      = (state_q == SCAN);
    assign bus.done      = (state_q == DONE);
    assign bus.converged = conv_q;
    assign bus.timeout   = tout_q;
    assign bus.max_delta = mdel_q;
    assign bus.iter_cnt  = iter_q;
endmodule

// File: tb/tb_centroid_converge_unit.sv
// Drives a P=1 and a P=2 instance with identical directed vectors and checks
// both against an arithmetic model every cycle, plus literal expectations.
module tb_centroid_converge_unit;
    localparam int K  = 2;
    localparam int D  = 2;
    localparam int W  = 8;
    localparam int IW = 8;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        start    = 1'b0;
    logic [31:0] old_c    = '0;
    logic [31:0] new_c    = '0;
    logic [7:0]  tol      = '0;
    logic [7:0]  max_iter = '0;
    logic        iter_clr = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    centroid_converge_unit_if #(.K(K), .D(D), .W(W), .ITER_W(IW)) b1 ();
    centroid_converge_unit_if #(.K(K), .D(D), .W(W), .ITER_W(IW)) b2 ();

    assign b1.start = start;    assign b2.start = start;
    assign b1.old_c = old_c;    assign b2.old_c = old_c;
    assign b1.new_c = new_c;    assign b2.new_c = new_c;
    assign b1.tol = tol;        assign b2.tol = tol;
    assign b1.max_iter = max_iter; assign b2.max_iter = max_iter;
    assign b1.iter_clr = iter_clr; assign b2.iter_clr = iter_clr;

    centroid_converge_unit #(.K(K), .D(D), .W(W), .P(1), .ITER_W(IW)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(b1.slave));
    centroid_converge_unit #(.K(K), .D(D), .W(W), .P(2), .ITER_W(IW)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(b2.slave));

    // ---------------- reference model ----------------
    // ph: 0 idle, 1..n busy slices, n+1 done cycle (n = elements / P)
    int ph[2]      = '{0, 0};
    int pend_md[2] = '{0, 0};
    bit pend_ok[2] = '{0, 0};
    int m_md[2]    = '{0, 0};
    bit m_conv[2]  = '{0, 0};
    bit m_to[2]    = '{0, 0};
    int m_iter[2]  = '{0, 0};

    function automatic int nslices(input int i);
        return (i == 0) ? 4 : 2;
    endfunction

    function automatic void calc(input logic [31:0] o, input logic [31:0] n,
                                 input logic [7:0] t, output int md, output bit ok);
        int a;
        int b;
        int d;
        logic [7:0] eo;
        logic [7:0] en;
        md = 0;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            eo = o[i*8 +: 8];
            en = n[i*8 +: 8];
            a  = int'($signed(eo));
            b  = int'($signed(en));
            d  = b - a;
            if (d < 0) d = -d;
            if (d > md) md = d;
            if (d > int'(t)) ok = 1'b0;
        end
    endfunction

    function automatic logic [31:0] pack(input int e0, input int e1, input int e2, input int e3);
        logic [31:0] v;
        v[7:0]   = e0[7:0];
        v[15:8]  = e1[7:0];
        v[23:16] = e2[7:0];
        v[31:24] = e3[7:0];
        return v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                ph[i] = 0; pend_md[i] = 0; pend_ok[i] = 0;
                m_md[i] = 0; m_conv[i] = 0; m_to[i] = 0; m_iter[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (ph[i] == 0) begin
                    if (start) begin
                        calc(old_c, new_c, tol, pend_md[i], pend_ok[i]);
                        ph[i] = 1;
                    end
                end else if (ph[i] < nslices(i)) begin
                    ph[i] = ph[i] + 1;
                end else if (ph[i] == nslices(i)) begin
                    ph[i]     = ph[i] + 1;
                    m_md[i]   = pend_md[i];
                    m_conv[i] = pend_ok[i];
                    m_iter[i] = (m_iter[i] == 255) ? 255 : m_iter[i] + 1;
                    m_to[i]   = !pend_ok[i] && (max_iter != 0) && (m_iter[i] >= int'(max_iter));
                end else begin
                    ph[i] = 0;
                end
                if (iter_clr) m_iter[i] = 0;
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_inst(input string tag, input int i, input logic busy, input logic done,
                            input logic conv, input logic to, input logic [8:0] md,
                            input logic [7:0] it);
        chk({tag, ".busy"}, int'(busy), int'(ph[i] >= 1 && ph[i] <= nslices(i)));
        chk({tag, ".done"}, int'(done), int'(ph[i] == nslices(i) + 1));
        chk({tag, ".converged"}, int'(conv), int'(m_conv[i]));
        chk({tag, ".timeout"}, int'(to), int'(m_to[i]));
        chk({tag, ".max_delta"}, int'(md), m_md[i]);
        chk({tag, ".iter_cnt"}, int'(it), m_iter[i]);
    endtask

    always @(negedge clk) begin
        cmp_inst("p1", 0, b1.busy, b1.done, b1.converged, b1.timeout, b1.max_delta, b1.iter_cnt);
        cmp_inst("p2", 1, b2.busy, b2.done, b2.converged, b2.timeout, b2.max_delta, b2.iter_cnt);
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    initial begin
        tick(1);
        rst_n = 1'b1;
        chk("rst.busy", int'(b1.busy), 0);
        chk("rst.done", int'(b1.done), 0);
        chk("rst.max_delta", int'(b1.max_delta), 0);
        chk("rst.iter_cnt", int'(b1.iter_cnt), 0);

        // identical sets, tol 0
        old_c = pack(1, 2, 3, 4); new_c = pack(1, 2, 3, 4); tol = 8'd0; max_iter = 8'd0;
        pulse_start();
        chk("t1.p1.busy", int'(b1.busy), 1);
        tick(2);
        chk("t1.p2.done", int'(b2.done), 1);
        chk("t1.p2.converged", int'(b2.converged), 1);
        tick(2);
        chk("t1.p1.done", int'(b1.done), 1);
        chk("t1.p1.converged", int'(b1.converged), 1);
        chk("t1.p1.max_delta", int'(b1.max_delta), 0);
        chk("t1.p1.iter_cnt", int'(b1.iter_cnt), 1);
        tick(1);
        chk("t1.p1.idle_done", int'(b1.done), 0);

        // extreme difference -128 -> 127
        old_c = pack(0, 0, -128, 0); new_c = pack(0, 0, 127, 0); tol = 8'd254;
        pulse_start();
        tick(4);
        chk("t2a.p1.converged", int'(b1.converged), 0);
        chk("t2a.p1.max_delta", int'(b1.max_delta), 255);
        chk("t2a.p2.max_delta", int'(b2.max_delta), 255);
        tick(1);
        tol = 8'd255;
        pulse_start();
        tick(4);
        chk("t2b.p1.converged", int'(b1.converged), 1);
        chk("t2b.p1.max_delta", int'(b1.max_delta), 255);
        chk("t2b.p1.iter_cnt", int'(b1.iter_cnt), 3);
        tick(1);

        // iteration limit
        iter_clr = 1'b1;
        tick(1);
        iter_clr = 1'b0;
        chk("t3.p1.iter_clr", int'(b1.iter_cnt), 0);
        max_iter = 8'd3; tol = 8'd0;
        old_c = pack(5, 0, 0, 0); new_c = pack(-5, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            pulse_start();
            tick(4);
            chk("t3.p1.timeout", int'(b1.timeout), (k == 2) ? 1 : 0);
            chk("t3.p1.max_delta", int'(b1.max_delta), 10);
            tick(1);
        end
        chk("t3.p1.iter_cnt", int'(b1.iter_cnt), 3);

        // reset during SCAN cycle 2
        pulse_start();
        tick(1);
        #1 rst_n = 1'b0;
        #1;
        chk("t4.p1.busy", int'(b1.busy), 0);
        chk("t4.p1.iter_cnt", int'(b1.iter_cnt), 0);
        chk("t4.p1.max_delta", int'(b1.max_delta), 0);
        chk("t4.p1.timeout", int'(b1.timeout), 0);
        tick(1);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick(1);
            chk("t4.p1.no_done", int'(b1.done), 0);
        end
        pulse_start();
        tick(4);
        chk("t4.p1.done", int'(b1.done), 1);
        chk("t4.p1.iter_cnt2", int'(b1.iter_cnt), 1);
        tick(1);

        // start held, inputs change mid-pass, iter_clr on DONE entry
        max_iter = 8'd0; tol = 8'd0;
        old_c = pack(7, -7, 100, -100); new_c = pack(7, -7, 100, -100);
        start = 1'b1;
        tick(1);
        old_c = pack(1, 1, 1, 1); new_c = pack(0, 0, 0, 0); tol = 8'hff;
        tick(3);
        iter_clr = 1'b1;
        tick(1);
        chk("t5.p1.done", int'(b1.done), 1);
        chk("t5.p1.converged", int'(b1.converged), 1);
        chk("t5.p1.max_delta", int'(b1.max_delta), 0);
        chk("t5.p1.iter_cnt", int'(b1.iter_cnt), 0);
        start = 1'b0; iter_clr = 1'b0;
        tick(3);
        chk("t5.p1.single_pass", int'(b1.busy), 0);

        // mixed deltas; P=2 must agree with P=1
        old_c = pack(10, -20, 30, -40); new_c = pack(13, -27, 30, -35); tol = 8'd6;
        pulse_start();
        tick(2);
        chk("t6.p2.done", int'(b2.done), 1);
        chk("t6.p2.max_delta", int'(b2.max_delta), 7);
        chk("t6.p2.converged", int'(b2.converged), 0);
        tick(2);
        chk("t6.p1.max_delta", int'(b1.max_delta), 7);
        chk("t6.p1.converged", int'(b1.converged), 0);
        tick(1);
        tol = 8'd7;
        pulse_start();
        tick(4);
        chk("t6b.p1.converged", int'(b1.converged), 1);
        chk("t6b.p2.converged", int'(b2.converged), 1);
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/centroid_converge_unit.md
CENTROID_CONVERGE_UNIT -- requirements
Module: centroid_converge_unit

Interface
REQ-001 SHALL have parameter K, default 8: number of centroids.
REQ-002 SHALL have parameter D, default 4: dimensions per centroid.
REQ-003 SHALL have parameter W, default 8: signed coordinate width.
REQ-004 SHALL have parameter P, default 1: elements compared per cycle; K*D divisible by P, otherwise invalid configuration.
REQ-005 SHALL have parameter ITER_W, default 8: iteration counter width.
REQ-006 SHALL have port clk, input, 1: single clock, rising edge.
REQ-007 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have port start, input, 1: request one comparison pass.
REQ-009 SHALL have port old_c, input, K*D*W: previous centroid set, signed, element i at [i*W +: W].
REQ-010 SHALL have port new_c, input, K*D*W: updated centroid set, same packing.
REQ-011 SHALL have port tol, input, W: unsigned per-element tolerance.
REQ-012 SHALL have port max_iter, input, ITER_W: iteration limit; 0 disables timeout.
REQ-013 SHALL have port iter_clr, input, 1: clear iteration counter.
REQ-014 SHALL have port busy, output, 1: pass in progress.
REQ-015 SHALL have port done, output, 1: single-cycle pass-complete pulse.
REQ-016 SHALL have port converged, output, 1: all elements within tol on last pass.
REQ-017 SHALL have port timeout, output, 1: limit reached without convergence.
REQ-018 SHALL have port max_delta, output, W+1: largest |new-old| on last pass, unsigned.
REQ-019 SHALL have port iter_cnt, output, ITER_W: completed passes since reset/clear.

Function
REQ-020 SHALL implement states IDLE, SCAN, DONE; IDLE->SCAN on start, SCAN->DONE after last slice, DONE->IDLE unconditionally.
REQ-021 SHALL snapshot old_c, new_c, tol into internal registers on the edge start is accepted; later input changes do not affect the pass.
REQ-022 SHALL accept start only in IDLE; start in SCAN or DONE is ignored, not queued.
REQ-023 SHALL process P elements per SCAN cycle, index 0 upward, for N = K*D/P cycles.
REQ-024 SHALL compute each difference in W+1 bits signed (sign-extend both operands), magnitude as W+1-bit unsigned; no overflow for any input pair.
REQ-025 SHALL treat an element as within tolerance when magnitude <= zero-extended tol.
REQ-026 SHALL scan all elements (no early exit) so max_delta is exact.
REQ-027 SHALL assert busy from the edge after start acceptance through the last SCAN cycle; busy low in IDLE and DONE.
REQ-028 SHALL assert done for exactly one cycle (DONE state), N+1 cycles after the start-sampling edge.
REQ-029 SHALL update converged, max_delta, timeout, iter_cnt at the edge entering DONE, holding them until the next DONE.
REQ-030 SHALL increment iter_cnt by one per completed pass, saturating at all-ones.
REQ-031 SHALL set timeout = !converged and max_iter != 0 and updated iter_cnt >= max_iter.
REQ-032 SHALL clear iter_cnt on iter_clr in any state; iter_clr coincident with DONE entry wins (iter_cnt=0), other results still update.
REQ-033 SHALL keep converged and timeout mutually exclusive.

Reset
REQ-034 SHALL on rst_n low, asynchronously: state IDLE; busy, done, converged, timeout = 0; max_delta = 0; iter_cnt = 0; snapshot registers = 0.
REQ-035 SHALL abort any pass in progress on reset, producing no done pulse afterwards.

Verification (K=2, D=2, W=8, P=1 unless noted)
REQ-036 SHALL verify identical sets, tol=0, start pulse -> busy 4 cycles, done at cycle 5, converged=1, max_delta=0, iter_cnt=1.
REQ-037 SHALL verify old elem2=-128, new elem2=127, rest equal: tol=254 -> converged=0, max_delta=255; tol=255 -> converged=1.
REQ-038 SHALL verify max_iter=3, non-converging sets, three passes -> timeout 0,0,1; iter_cnt=3.
REQ-039 SHALL verify rst_n low during SCAN cycle 2 -> outputs zero immediately, no done pulse, next start completes normally.
REQ-040 SHALL verify start held high throughout a pass and inputs changed mid-SCAN -> one pass only, results from snapshot; iter_clr with DONE -> iter_cnt=0.
REQ-041 SHALL verify P=2: done at cycle 3 after start, results identical to P=1 run on same data.
